// File: rtl/sevenseg_pkg.sv
// Shared glyph codes, segment table and frame record for the seven-segment controller.
package sevenseg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MAX_CHAR_W = 5;

  // Extended glyph codes (0-15 are the hex digits)
  localparam logic [4:0] GLYPH_BLANK  = 5'd16;
  localparam logic [4:0] GLYPH_DASH   = 5'd17;
  localparam logic [4:0] GLYPH_H      = 5'd18;
  localparam logic [4:0] GLYPH_L      = 5'd19;
  localparam logic [4:0] GLYPH_P      = 5'd20;
  localparam logic [4:0] GLYPH_R      = 5'd21;
  localparam logic [4:0] GLYPH_N      = 5'd22;
  localparam logic [4:0] GLYPH_O      = 5'd23;
  localparam logic [4:0] GLYPH_U      = 5'd24;
  localparam logic [4:0] GLYPH_Y      = 5'd25;
  localparam logic [4:0] GLYPH_UNDER  = 5'd26;
  localparam logic [4:0] GLYPH_DEGREE = 5'd27;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low segments gfedcba, indexed by glyph code
  localparam logic [6:0] SEG_TABLE [32] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
    7'h7F, 7'h3F, 7'h09, 7'h47, 7'h0C, 7'h2F, 7'h2B, 7'h23,
    7'h41, 7'h11, 7'h77, 7'h1C, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  // Sized for the largest configuration; unused digits stay zero
  typedef struct packed {
    logic [MAX_DIGITS-1:0][MAX_CHAR_W-1:0] chars;
    logic [MAX_DIGITS-1:0]                 dp;
    logic [MAX_DIGITS-1:0]                 blank;
    logic [MAX_DIGITS-1:0]                 blink;
    logic [3:0]                            bright;
  } display_frame_t;

  // Power-on frame: every digit blanked, full brightness
  function automatic display_frame_t reset_frame();
    display_frame_t f;
    f = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      f.chars[i] = GLYPH_BLANK;
    end
    f.blank  = '1;
    f.bright = 4'hF;
    return f;
  endfunction

endpackage

// File: rtl/sevenseg_glyph_rom.sv
// Combinational glyph decoder: code -> active-low a..g segments.
module sevenseg_glyph_rom
  import sevenseg_pkg::*;
#(
  parameter int CHAR_W = 5
) (
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        seg
);

  logic [4:0] idx;

  // Narrow codes zero-extend, so a 4-bit build only ever reaches 0-15
  assign idx = 5'(code);
  assign seg = SEG_TABLE[idx];

endmodule

// File: rtl/sevenseg_display_ctrl.sv
// N-digit seven-segment controller with double-buffered frames, blink and PWM dimming.
module sevenseg_display_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CHAR_W     = 5,
  parameter int PWM_DIV    = 64,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                         clock,
  input  logic                         reset_L,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [NUM_DIGITS*CHAR_W-1:0] ld_chars,
  input  logic [NUM_DIGITS-1:0]        ld_dp,
  input  logic [NUM_DIGITS-1:0]        ld_blank,
  input  logic [NUM_DIGITS-1:0]        ld_blink,
  input  logic [3:0]                   ld_bright,
  output logic [NUM_DIGITS*8-1:0]      hex,
  output logic                         upd_done
);

  localparam int PD_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  display_frame_t pend_frame;
  display_frame_t disp_frame;
  display_frame_t ld_frame;
  logic           pending;

  logic [PD_W-1:0] pwm_div;
  logic [3:0]      pwm_cnt;
  logic [BL_W-1:0] blink_cnt;
  logic            blink_phase;
  logic            commit_d;

  logic pwm_wrap;
  logic blink_wrap;
  logic frame_end;
  logic accept;
  logic commit;

  logic [NUM_DIGITS-1:0][6:0]     seg;
  logic [NUM_DIGITS*8-1:0]        hex_next;
  logic                           unused_disp;

  assign ld_ready   = !pending;
  assign accept     = ld_valid && ld_ready;
  assign pwm_wrap   = (pwm_div == PD_W'(PWM_DIV - 1));
  assign blink_wrap = (blink_cnt == BL_W'(BLINK_DIV - 1));
  assign frame_end  = pwm_wrap && (pwm_cnt == 4'hF);
  assign commit     = frame_end && pending;

  // Frame bits beyond the configured digit count / code width are never decoded
  assign unused_disp = ^disp_frame;

  // Repack the flat load bus into the frame record
  always_comb begin
    ld_frame        = '0;
    ld_frame.bright = ld_bright;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      ld_frame.chars[i] = MAX_CHAR_W'(ld_chars[i*CHAR_W +: CHAR_W]);
      ld_frame.dp[i]    = ld_dp[i];
      ld_frame.blank[i] = ld_blank[i];
      ld_frame.blink[i] = ld_blink[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    sevenseg_glyph_rom #(
      .CHAR_W (CHAR_W)
    ) u_rom (
      .code (disp_frame.chars[g][CHAR_W-1:0]),
      .seg  (seg[g])
    );
  end

  // Per-digit visibility: blank mask, blink phase and PWM duty all gate the digit
  always_comb begin
    hex_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!disp_frame.blank[i] && !(disp_frame.blink[i] && blink_phase) &&
          (pwm_cnt <= disp_frame.bright)) begin
        hex_next[i*8 +: 8] = {~disp_frame.dp[i], seg[i]};
      end else begin
        hex_next[i*8 +: 8] = SEG_OFF;
      end
    end
  end

  // PWM step/frame counters and free-running blink timebase
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pwm_div     <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_div <= pwm_wrap ? '0 : pwm_div + PD_W'(1);
      if (pwm_wrap) begin
        pwm_cnt <= pwm_cnt + 4'd1;
      end
      blink_cnt <= blink_wrap ? '0 : blink_cnt + BL_W'(1);
      if (blink_wrap) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

  // Load handshake into the pending buffer; swap to display only at a frame boundary
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      pend_frame <= reset_frame();
      disp_frame <= reset_frame();
      pending    <= 1'b0;
    end else if (accept) begin
      pend_frame <= ld_frame;
      pending    <= 1'b1;
    end else if (commit) begin
      disp_frame <= pend_frame;
      pending    <= 1'b0;
    end
  end

  // Registered outputs; upd_done lines up with the first hex word built from the new frame
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      hex      <= '1;
      commit_d <= 1'b0;
      upd_done <= 1'b0;
    end else begin
      hex      <= hex_next;
      commit_d <= commit;
      upd_done <= commit_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
// Directed bench for sevenseg_display_ctrl (6 digits, PWM_DIV=1, BLINK_DIV=8).
module tb_sevenseg_display_ctrl;

  localparam int ND = 6;
  localparam int CW = 5;

  logic              clock = 1'b0;
  logic              reset_L;
  logic              ld_valid;
  logic              ld_ready;
  logic [ND*CW-1:0]  ld_chars;
  logic [ND-1:0]     ld_dp;
  logic [ND-1:0]     ld_blank;
  logic [ND-1:0]     ld_blink;
  logic [3:0]        ld_bright;
  logic [ND*8-1:0]   hex;
  logic              upd_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [ND*CW-1:0] chars;
    logic [ND-1:0]    dp;
    logic [ND-1:0]    blank;
    logic [ND-1:0]    blink;
    logic [3:0]       bright;
    logic [ND*8-1:0]  exp_hex;
  } vec_t;

  vec_t vecs [5];

  sevenseg_display_ctrl #(
    .NUM_DIGITS (ND),
    .CHAR_W     (CW),
    .PWM_DIV    (1),
    .BLINK_DIV  (8)
  ) dut (
    .clock     (clock),
    .reset_L   (reset_L),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_chars  (ld_chars),
    .ld_dp     (ld_dp),
    .ld_blank  (ld_blank),
    .ld_blink  (ld_blink),
    .ld_bright (ld_bright),
    .hex       (hex),
    .upd_done  (upd_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(logic [ND*CW-1:0] c, logic [ND-1:0] d, logic [ND-1:0] bl,
                              logic [ND-1:0] bk, logic [3:0] br, logic [ND*8-1:0] e);
    vec_t v;
    v.chars = c; v.dp = d; v.blank = bl; v.blink = bk; v.bright = br; v.exp_hex = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ld_chars  = v.chars;
    ld_dp     = v.dp;
    ld_blank  = v.blank;
    ld_blink  = v.blink;
    ld_bright = v.bright;
  endtask

  // Hold valid until a ready edge transfers the payload
  task automatic load(input vec_t v, input string name);
    bit ok;
    ok = 1'b0;
    drive(v);
    ld_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (ld_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    ld_valid = 1'b0;
    chk({name, " accepted"}, 64'(ok), 64'd1);
    chk({name, " ready low after accept"}, 64'(ld_ready), 64'd0);
  endtask

  task automatic wait_upd(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (upd_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, " upd_done seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    bit   ok;
    int   lit;
    int   t1, t2;
    int   last_chg, n_chg, bad_run;
    logic prev_lit, cur_lit;
    logic d1_steady;
    logic [ND*8-1:0] prev_hex;
    int   n_upd;
    logic all_off;

    vecs[0] = mk({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 6'b000000, 6'b000000, 6'b000000,
                 4'd15, 48'h92_99_B0_A4_F9_C0);
    vecs[1] = mk({5'd26, 5'd27, 5'd17, 5'd30, 5'd18, 5'd0}, 6'b000001, 6'b000000, 6'b000000,
                 4'd15, 48'hF7_9C_BF_FF_89_40);
    vecs[2] = mk({5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10}, 6'b100000, 6'b001010, 6'b000000,
                 4'd15, 48'h0E_86_FF_C6_FF_88);
    vecs[3] = mk({5'd24, 5'd23, 5'd22, 5'd21, 5'd20, 5'd19}, 6'b111111, 6'b000000, 6'b000000,
                 4'd3, 48'h41_23_2B_2F_0C_47);
    vecs[4] = mk({5'd28, 5'd25, 5'd9, 5'd8, 5'd7, 5'd6}, 6'b000000, 6'b000000, 6'b000000,
                 4'd15, 48'hFF_91_90_80_F8_82);

    reset_L   = 1'b0;
    ld_valid  = 1'b0;
    ld_chars  = '0;
    ld_dp     = '0;
    ld_blank  = '0;
    ld_blink  = '0;
    ld_bright = '0;

    // Reset state
    repeat (3) tick();
    chk("reset hex", 64'(hex), 64'(48'hFFFF_FFFF_FFFF));
    chk("reset ld_ready", 64'(ld_ready), 64'd1);
    chk("reset upd_done", 64'(upd_done), 64'd0);
    reset_L = 1'b1;
    all_off = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (hex !== 48'hFFFF_FFFF_FFFF || upd_done !== 1'b0) all_off = 1'b0;
    end
    chk("idle after reset stays blank", 64'(all_off), 64'd1);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      load(vecs[i], $sformatf("vec%0d", i));
      wait_upd($sformatf("vec%0d", i), ok);
      chk($sformatf("vec%0d hex", i), 64'(hex), 64'(vecs[i].exp_hex));
      chk($sformatf("vec%0d ready back", i), 64'(ld_ready), 64'd1);
      tick();
      chk($sformatf("vec%0d single pulse", i), 64'(upd_done), 64'd0);
      if (vecs[i].bright != 4'd15) begin
        lit = (hex[7:0] != 8'hFF) ? 1 : 0;
        for (int k = 0; k < 15; k++) begin
          tick();
          if (hex[7:0] != 8'hFF) lit++;
        end
        chk($sformatf("vec%0d duty", i), 64'(lit), 64'(vecs[i].bright) + 64'd1);
      end
    end

    // Blink on digit 0 only
    load(mk({5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, 6'b0, 6'b0, 6'b000001, 4'd15, '0), "blink");
    wait_upd("blink", ok);
    lit = 0; n_chg = 0; bad_run = 0; last_chg = -1; d1_steady = 1'b1;
    prev_lit = (hex[7:0] == 8'hC0);
    for (int k = 0; k < 32; k++) begin
      tick();
      cur_lit = (hex[7:0] == 8'hC0);
      if (!cur_lit && hex[7:0] != 8'hFF) bad_run++;
      if (cur_lit) lit++;
      if (cur_lit != prev_lit) begin
        if (last_chg >= 0 && (k - last_chg) != 8) bad_run++;
        last_chg = k;
        n_chg++;
      end
      prev_lit = cur_lit;
      if (hex[47:8] !== 40'h92_99_B0_A4_F9) d1_steady = 1'b0;
    end
    chk("blink lit cycles of 32", 64'(lit), 64'd16);
    chk("blink run length 8", 64'(bad_run), 64'd0);
    chk("blink toggles present", 64'(n_chg >= 3), 64'd1);
    chk("blink other digits steady", 64'(d1_steady), 64'd1);

    // Back-to-back: second load waits for the first commit
    load(vecs[2], "b2b first");
    drive(vecs[4]);
    ld_valid = 1'b1;
    t1 = -1; t2 = -1;
    prev_hex = hex;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (upd_done) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b first hex", 64'(hex), 64'(vecs[2].exp_hex));
          chk("b2b second taken after commit", 64'(ld_ready), 64'd0);
          ld_valid = 1'b0;
        end else begin
          t2 = cyc;
          chk("b2b second hex", 64'(hex), 64'(vecs[4].exp_hex));
          chk("b2b first held before swap", 64'(prev_hex), 64'(vecs[2].exp_hex));
          break;
        end
      end
      prev_hex = hex;
    end
    ld_valid = 1'b0;
    chk("b2b both frames shown", 64'(t1 >= 0 && t2 >= 0), 64'd1);
    chk("b2b frame spacing", 64'(t2 - t1), 64'd16);

    // Async reset with a load pending
    load(vecs[1], "rst pending");
    #2;
    reset_L = 1'b0;
    #1;
    chk("async reset hex", 64'(hex), 64'(48'hFFFF_FFFF_FFFF));
    chk("async reset ready", 64'(ld_ready), 64'd1);
    chk("async reset upd_done", 64'(upd_done), 64'd0);
    tick();
    tick();
    reset_L = 1'b1;
    n_upd = 0;
    all_off = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (upd_done) n_upd++;
      if (hex !== 48'hFFFF_FFFF_FFFF) all_off = 1'b0;
    end
    chk("post reset no upd_done", 64'(n_upd), 64'd0);
    chk("post reset pending discarded", 64'(all_off), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
